// File: rtl/regfile_pkg.sv
// Shared types and helpers for the integer register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int MAX_WB    = 8;

  typedef logic [AW_DEF-1:0] reg_idx_t;
  typedef logic [MAX_WB-1:0] wb_vec_t;

  localparam reg_idx_t ZERO_REG = '0;

  // Reduces the per-port hit vector for one register index to a one-hot
  // select of the highest-numbered hitting port (newest value wins).
  function automatic wb_vec_t highest_hit(input wb_vec_t hits);
    wb_vec_t sel;
    sel = '0;
    for (int k = MAX_WB - 1; k >= 0; k--) begin
      if (hits[k] && (sel == '0)) sel[k] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard detection, stall generation and
// flush > issue-set > write-back-clear busy update.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         issue_valid_i,
  input  logic [NREAD-1:0]             src_en_i,
  input  logic [NREAD-1:0][AW-1:0]     src_reg_i,
  input  logic                         dst_valid_i,
  input  logic [AW-1:0]                dst_reg_i,
  input  logic [NWRITE-1:0]            wb_valid_i,
  input  logic [NWRITE-1:0][AW-1:0]    wb_reg_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         accept_o,
  output logic [NREGS-1:0]             busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             raw, waw;

  function automatic logic wb_hit(input logic [AW-1:0] r);
    logic h;
    h = 1'b0;
    for (int k = 0; k < NWRITE; k++) begin
      if (wb_valid_i[k] && (wb_reg_i[k] == r) && (r != AW'(ZERO_REG))) h = 1'b1;
    end
    return h;
  endfunction

  always_comb begin
    raw = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      if (src_en_i[p] && (src_reg_i[p] != AW'(ZERO_REG)) &&
          busy_q[src_reg_i[p]] && !wb_hit(src_reg_i[p])) raw = 1'b1;
    end
    waw = dst_valid_i && (dst_reg_i != AW'(ZERO_REG)) &&
          busy_q[dst_reg_i] && !wb_hit(dst_reg_i);
    stall_o  = issue_valid_i && (raw || waw || flush_i);
    accept_o = issue_valid_i && !stall_o;
  end

  // Lowest priority first so later assignments override.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (wb_hit(AW'(r))) busy_d[r] = 1'b0;
    end
    if (accept_o && dst_valid_i && (dst_reg_i != AW'(ZERO_REG))) busy_d[dst_reg_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass, registered read ports and
// an integrated busy-bit scoreboard for the issue stage.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         irf_issue_valid,
  input  logic [NREAD-1:0]             irf_src_en,
  input  logic [NREAD-1:0][AW-1:0]     irf_src_reg,
  input  logic                         irf_dst_valid,
  input  logic [AW-1:0]                irf_dst_reg,
  input  logic [NWRITE-1:0]            irf_wb_valid,
  input  logic [NWRITE-1:0][AW-1:0]    irf_wb_reg,
  input  logic [NWRITE-1:0][XLEN-1:0]  irf_wb_data,
  input  logic                         irf_flush,
  output logic [NREAD-1:0][XLEN-1:0]   orf_src_data,
  output logic                         orf_issue_ack,
  output logic                         orf_stall,
  output logic [NREGS-1:0]             orf_busy
);

  logic                          accept;
  logic [XLEN-1:0]               regs_q [NREGS];
  logic [XLEN-1:0]               regs_d [NREGS];
  logic [NREAD-1:0][XLEN-1:0]    rd_data;
  logic [NREAD-1:0][XLEN-1:0]    src_data_q;
  logic                          ack_q;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk           (clk),
    .reset_n       (reset_n),
    .issue_valid_i (irf_issue_valid),
    .src_en_i      (irf_src_en),
    .src_reg_i     (irf_src_reg),
    .dst_valid_i   (irf_dst_valid),
    .dst_reg_i     (irf_dst_reg),
    .wb_valid_i    (irf_wb_valid),
    .wb_reg_i      (irf_wb_reg),
    .flush_i       (irf_flush),
    .stall_o       (orf_stall),
    .accept_o      (accept),
    .busy_o        (orf_busy)
  );

  // Newest value of register r this cycle; serves both the read bypass and
  // the array write, so a read always matches what the array will hold.
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] r);
    wb_vec_t         hits;
    wb_vec_t         sel;
    logic [XLEN-1:0] v;
    hits = '0;
    v    = regs_q[r];
    for (int k = 0; k < NWRITE; k++) begin
      if (irf_wb_valid[k] && (irf_wb_reg[k] == r)) hits[k] = 1'b1;
    end
    sel = highest_hit(hits);
    for (int k = 0; k < NWRITE; k++) begin
      if (sel[k]) v = irf_wb_data[k];
    end
    if (r == AW'(ZERO_REG)) v = '0;
    return v;
  endfunction

  always_comb begin
    for (int r = 0; r < NREGS; r++) regs_d[r] = fwd(AW'(r));
    for (int p = 0; p < NREAD; p++) rd_data[p] = fwd(irf_src_reg[p]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      src_data_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
      ack_q <= accept;
      if (accept) src_data_q <= rd_data;
    end
  end

  assign orf_src_data  = src_data_q;
  assign orf_issue_ack = ack_q;

  // Two write-back ports targeting the same non-zero register is illegal.
  for (genvar i = 0; i < NWRITE; i++) begin : g_wb_a
    for (genvar j = i + 1; j < NWRITE; j++) begin : g_wb_b
      a_wb_unique: assert property (@(posedge clk) disable iff (!reset_n)
        !(irf_wb_valid[i] && irf_wb_valid[j] &&
          (irf_wb_reg[i] == irf_wb_reg[j]) && (irf_wb_reg[i] != AW'(ZERO_REG))))
        else $error("regfile_sb: write-back ports %0d and %0d hit the same register", i, j);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: table of per-cycle vectors with a
// scoreboard queue for registered outputs, plus an async-reset sequence.
module tb_regfile_sb;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic                         irf_issue_valid;
  logic [NREAD-1:0]             irf_src_en;
  logic [NREAD-1:0][AW-1:0]     irf_src_reg;
  logic                         irf_dst_valid;
  logic [AW-1:0]                irf_dst_reg;
  logic [NWRITE-1:0]            irf_wb_valid;
  logic [NWRITE-1:0][AW-1:0]    irf_wb_reg;
  logic [NWRITE-1:0][XLEN-1:0]  irf_wb_data;
  logic                         irf_flush;
  logic [NREAD-1:0][XLEN-1:0]   orf_src_data;
  logic                         orf_issue_ack;
  logic                         orf_stall;
  logic [NREGS-1:0]             orf_busy;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .irf_issue_valid (irf_issue_valid),
    .irf_src_en      (irf_src_en),
    .irf_src_reg     (irf_src_reg),
    .irf_dst_valid   (irf_dst_valid),
    .irf_dst_reg     (irf_dst_reg),
    .irf_wb_valid    (irf_wb_valid),
    .irf_wb_reg      (irf_wb_reg),
    .irf_wb_data     (irf_wb_data),
    .irf_flush       (irf_flush),
    .orf_src_data    (orf_src_data),
    .orf_issue_ack   (orf_issue_ack),
    .orf_stall       (orf_stall),
    .orf_busy        (orf_busy)
  );

  typedef struct {
    logic        issue;
    logic [1:0]  en;
    logic [4:0]  s0, s1;
    logic        dv;
    logic [4:0]  dst;
    logic [1:0]  wbv;
    logic [4:0]  w0;
    logic [63:0] d0;
    logic [4:0]  w1;
    logic [63:0] d1;
    logic        flush;
    logic        stall;
    logic        ack;
    logic [63:0] e0, e1;
    logic [31:0] busy;
  } vec_t;

  typedef struct {
    int          id;
    logic        ack;
    logic [63:0] e0, e1;
    logic [31:0] busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic issue, input logic [1:0] en, input logic [4:0] s0, input logic [4:0] s1,
                     input logic dv, input logic [4:0] dst, input logic [1:0] wbv,
                     input logic [4:0] w0, input logic [63:0] d0, input logic [4:0] w1, input logic [63:0] d1,
                     input logic flush, input logic stall, input logic ack,
                     input logic [63:0] e0, input logic [63:0] e1, input logic [31:0] busy);
    vec_t v;
    v.issue = issue; v.en = en; v.s0 = s0; v.s1 = s1; v.dv = dv; v.dst = dst;
    v.wbv = wbv; v.w0 = w0; v.d0 = d0; v.w1 = w1; v.d1 = d1; v.flush = flush;
    v.stall = stall; v.ack = ack; v.e0 = e0; v.e1 = e1; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    irf_issue_valid = v.issue;
    irf_src_en      = v.en;
    irf_src_reg[0]  = v.s0;
    irf_src_reg[1]  = v.s1;
    irf_dst_valid   = v.dv;
    irf_dst_reg     = v.dst;
    irf_wb_valid    = v.wbv;
    irf_wb_reg[0]   = v.w0;
    irf_wb_data[0]  = v.d0;
    irf_wb_reg[1]   = v.w1;
    irf_wb_data[1]  = v.d1;
    irf_flush       = v.flush;
  endtask

  task automatic idle();
    irf_issue_valid = 1'b0;
    irf_src_en      = '0;
    irf_src_reg     = '0;
    irf_dst_valid   = 1'b0;
    irf_dst_reg     = '0;
    irf_wb_valid    = '0;
    irf_wb_reg      = '0;
    irf_wb_data     = '0;
    irf_flush       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    idle();
    reset_n = 1'b0;

    // issue en s0 s1 dv dst wbv w0 d0 w1 d1 flush | stall ack e0 e1 busy
    add(0, 2'b00, 0, 0, 0, 0, 2'b01, 5, 64'h1234, 0, 0, 0,      0, 0, 64'h0, 64'h0, 32'h0);
    add(1, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h1234, 64'h0, 32'h0);
    add(1, 2'b00, 0, 0, 1, 7, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h0, 64'h0, 32'h80);
    add(1, 2'b10, 0, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0,             1, 0, 64'h0, 64'h0, 32'h80);
    add(1, 2'b10, 0, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0,             1, 0, 64'h0, 64'h0, 32'h80);
    add(1, 2'b10, 0, 7, 0, 0, 2'b10, 0, 0, 7, 64'hAB, 0,        0, 1, 64'h0, 64'hAB, 32'h0);
    add(0, 2'b00, 0, 0, 0, 0, 2'b01, 0, 64'hFFFF, 0, 0, 0,      0, 0, 64'h0, 64'hAB, 32'h0);
    add(1, 2'b11, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h0, 64'h1234, 32'h0);
    add(1, 2'b00, 0, 0, 1, 3, 2'b01, 3, 64'h33, 0, 0, 0,        0, 1, 64'h0, 64'h0, 32'h8);
    add(1, 2'b01, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,             1, 0, 64'h0, 64'h0, 32'h8);
    add(1, 2'b01, 3, 0, 0, 0, 2'b01, 3, 64'h55, 0, 0, 0,        0, 1, 64'h55, 64'h0, 32'h0);
    add(1, 2'b00, 0, 0, 1, 2, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h0, 64'h0, 32'h4);
    add(1, 2'b01, 3, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h55, 64'h0, 32'h204);
    add(1, 2'b00, 0, 0, 1, 2, 2'b00, 0, 0, 0, 0, 0,             1, 0, 64'h55, 64'h0, 32'h204);
    add(1, 2'b00, 0, 0, 1, 2, 2'b01, 4, 64'h44, 0, 0, 1,        1, 0, 64'h55, 64'h0, 32'h0);
    add(1, 2'b01, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h44, 64'h0, 32'h0);
    add(1, 2'b11, 10, 11, 0, 0, 2'b11, 10, 64'hA0, 11, 64'hB0, 0, 0, 1, 64'hA0, 64'hB0, 32'h0);
    add(1, 2'b11, 11, 10, 0, 0, 2'b00, 0, 0, 0, 0, 0,           0, 1, 64'hB0, 64'hA0, 32'h0);
    add(1, 2'b00, 0, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h0, 64'h0, 32'h200);
    add(1, 2'b00, 0, 0, 1, 9, 2'b10, 0, 0, 9, 64'h99, 0,        0, 1, 64'h0, 64'h0, 32'h200);
    add(1, 2'b10, 0, 9, 0, 0, 2'b00, 0, 0, 0, 0, 0,             1, 0, 64'h0, 64'h0, 32'h200);
    add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1,             0, 0, 64'h0, 64'h0, 32'h0);
    add(1, 2'b10, 0, 9, 0, 0, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h0, 64'h99, 32'h0);
    add(1, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0,             0, 1, 64'h0, 64'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", orf_busy, 64'h0);
    chk("reset ack", orf_issue_ack, 64'h0);
    chk("reset data0", orf_src_data[0], 64'h0);
    chk("reset data1", orf_src_data[1], 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post-reset stall", orf_stall, 64'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 chk($sformatf("v%0d stall", i), orf_stall, vecs[i].stall);
      sb.push_back('{i, vecs[i].ack, vecs[i].e0, vecs[i].e1, vecs[i].busy});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d ack", e.id), orf_issue_ack, e.ack);
        chk($sformatf("v%0d data0", e.id), orf_src_data[0], e.e0);
        chk($sformatf("v%0d data1", e.id), orf_src_data[1], e.e1);
        chk($sformatf("v%0d busy", e.id), orf_busy, e.busy);
      end
    end

    // Async reset between edges with a busy bit set and live output data.
    @(negedge clk);
    idle();
    irf_issue_valid = 1'b1;
    irf_src_en      = 2'b01;
    irf_src_reg[0]  = 5'd4;
    irf_dst_valid   = 1'b1;
    irf_dst_reg     = 5'd12;
    #1 chk("rst-seq stall", orf_stall, 64'h0);
    @(posedge clk);
    #1;
    chk("rst-seq pre ack", orf_issue_ack, 64'h1);
    chk("rst-seq pre data0", orf_src_data[0], 64'h44);
    chk("rst-seq pre busy", orf_busy, 64'h1000);
    #2 reset_n = 1'b0;
    #1;
    chk("rst-seq busy", orf_busy, 64'h0);
    chk("rst-seq ack", orf_issue_ack, 64'h0);
    chk("rst-seq data0", orf_src_data[0], 64'h0);
    chk("rst-seq data1", orf_src_data[1], 64'h0);
    @(posedge clk);
    #1 chk("rst-seq held ack", orf_issue_ack, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    irf_dst_valid  = 1'b0;
    irf_src_en     = 2'b11;
    irf_src_reg[0] = 5'd5;
    irf_src_reg[1] = 5'd4;
    #1;
    chk("rst-seq release ack", orf_issue_ack, 64'h0);
    chk("rst-seq release stall", orf_stall, 64'h0);
    @(posedge clk);
    #1;
    chk("rst-seq reread ack", orf_issue_ack, 64'h1);
    chk("rst-seq reread x5", orf_src_data[0], 64'h0);
    chk("rst-seq reread x4", orf_src_data[1], 64'h0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1 chk("rst-seq single ack", orf_issue_ack, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated busy-bit scoreboard, for the decode/issue stage of the pipeline. It provides NREAD registered read ports and NWRITE write-back ports, with write-back-to-read bypass. It detects RAW and WAW hazards against in-flight destinations and raises a stall. Register x0 is hardwired to zero.

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NREAD, 2, number of read ports
- NWRITE, 2, number of write-back ports
- AW, $clog2(NREGS), register index width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- irf_issue_valid  in  1  decode presents an instruction for issue
- irf_src_en  in  NREAD  per-port "source used" enable
- irf_src_reg  in  NREAD×AW  source register indices
- irf_dst_valid  in  1  instruction writes a destination
- irf_dst_reg  in  AW  destination index
- irf_wb_valid  in  NWRITE  write-back strobes
- irf_wb_reg  in  NWRITE×AW  write-back indices
- irf_wb_data  in  NWRITE×XLEN  write-back data
- irf_flush  in  1  clear all busy bits (pipeline squash)
- orf_src_data  out  NREAD×XLEN  registered source operands
- orf_issue_ack  out  1  registered; the issue was accepted in the previous cycle
- orf_stall  out  1  combinational; the issue is not accepted this cycle
- orf_busy  out  NREGS  scoreboard state (debug/verification)

## Operation
- Reset: all registers = 0, all busy = 0, orf_src_data = 0, orf_issue_ack = 0.
- Hit: write-back port k hits reg r when irf_wb_valid[k] && irf_wb_reg[k]==r && r!=0.
- RAW hazard: an enabled source s has s!=0, busy[s]=1, and no write-back hit on s this cycle.
- WAW hazard: irf_dst_valid, dst!=0, busy[dst]=1, and no write-back hit on dst this cycle.
- orf_stall = irf_issue_valid && (RAW || WAW || irf_flush).
- Accept = irf_issue_valid && !orf_stall.
- Read value per port:
  - x0 → 0.
  - Otherwise the value of the highest-index write-back port hitting the source this cycle (bypass).
  - Otherwise the array value.
- Register array: each hit writes irf_wb_data. If several ports hit the same register, the highest index wins; this is a protocol violation and must be flagged by an assertion.
- Busy update, priority high→low:
  1. irf_flush → all busy = 0.
  2. Accept with dst_valid and dst!=0 → busy[dst] = 1. This wins over a same-cycle write-back clear of the same register.
  3. Write-back hit → busy[r] = 0.
- Write-backs are always honoured, including during flush and stall.
- busy[0] is permanently 0.

## Timing
- Read latency is 1 cycle. On accept, orf_src_data is loaded at the edge and orf_issue_ack = 1 for exactly one cycle.
- Without accept, orf_src_data holds its value and orf_issue_ack = 0.
- Write-back to read: same-cycle visibility via bypass. The array is updated at the edge.
- Issue to busy: visible to the next cycle's hazard check, so back-to-back dependent issues stall.
- orf_stall is purely combinational from inputs and busy state. There is no dependence on orf_stall itself.
- reset_n assertion mid-operation clears all state immediately, with no clock required. Outputs hold their reset values until the first edge after deassertion.

## Structure
- Package regfile_pkg:
  - XLEN/NREGS defaults
  - reg_idx_t typedef
  - ZERO_REG constant
  - a function computing the highest-priority write-back hit per index
- Sub-module rf_scoreboard owns the busy vector, hazard detection, and the flush/set/clear priority.
- The top level owns the array, bypass muxes, and output registers.

## Test plan
- Reset, then write-back x5=0x1234 on port 0; next cycle issue src0=x5 → orf_src_data[0]=0x1234 one cycle later, orf_issue_ack=1.
- Issue with dst=x7 (accepted), then next cycle issue src1=x7 → orf_stall=1. Write-back x7=0xAB on port 1 in a later cycle while the issue is still held → orf_stall=0 that cycle, and orf_src_data[1]=0xAB (bypass).
- Write-back x0=0xFFFF; issue src0=x0 → data 0, no stall, orf_busy[0]=0.
- Same cycle: accepted issue dst=x3 and write-back x3 → orf_busy[3]=1 after the edge.
- Set busy on x2 and x9, assert irf_flush with irf_issue_valid=1 → orf_stall=1, no ack. All busy = 0 next cycle; the write-back in the flush cycle is stored.
- Pull reset_n low between edges with busy bits set → orf_busy=0, orf_issue_ack=0, and the array reads 0 immediately.
